// File: rtl/pixel_fifo_pkg.sv
// Shared definitions for both sides of the ping-pong pixel FIFO.
// Word layout: {last, R, G, B} in a 25-bit word, plus the writer FSM state encoding.
package pixel_fifo_pkg;

  localparam int unsigned PIX_WORD_WIDTH = 25;
  localparam int unsigned PIX_LAST_BIT   = 24;
  localparam int unsigned PIX_R_MSB      = 23;
  localparam int unsigned PIX_R_LSB      = 16;
  localparam int unsigned PIX_G_MSB      = 15;
  localparam int unsigned PIX_G_LSB      = 8;
  localparam int unsigned PIX_B_MSB      = 7;
  localparam int unsigned PIX_B_LSB      = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    DRAIN   = 2'd2,
    RELEASE = 2'd3
  } writer_state_e;

endpackage

// File: rtl/pixel_writer_if.sv
// Pixel-writer bus: upstream RGB888 valid/ready stream plus the ppfifo write port.
// Signal names keep their direction as seen from the writer (i_* into it, o_* out of it).
//   slave  : the writer itself
//   master : the environment (pixel source and ppfifo write side)
interface pixel_writer_if #(
  parameter int unsigned SIZE_WIDTH = 24
);
  import pixel_fifo_pkg::*;

  // Pixel stream
  logic [7:0]                i_red;
  logic [7:0]                i_green;
  logic [7:0]                i_blue;
  logic                      i_last;
  logic                      i_pixel_valid;
  logic                      o_pixel_rdy;

  // ppfifo write port
  logic [1:0]                i_write_rdy;
  logic [1:0]                o_write_act;
  logic [SIZE_WIDTH-1:0]     i_write_size;
  logic                      o_write_stb;
  logic [PIX_WORD_WIDTH-1:0] o_write_data;

  modport slave (
    input  i_red, i_green, i_blue, i_last, i_pixel_valid, i_write_rdy, i_write_size,
    output o_pixel_rdy, o_write_act, o_write_stb, o_write_data
  );

  modport master (
    output i_red, i_green, i_blue, i_last, i_pixel_valid, i_write_rdy, i_write_size,
    input  o_pixel_rdy, o_write_act, o_write_stb, o_write_data
  );

endinterface

// File: rtl/pixel_writer.sv
// Write-side producer for the ping-pong pixel FIFO.
// Accepts RGB888 pixels over valid/ready, packs them as {last, R, G, B} and writes them
// into whichever ppfifo buffer it has activated, releasing the buffer when it is full
// or (optionally) after an end-of-frame pixel.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_enable       when low no pixels are accepted; the active buffer is held
//   bus            pixel_writer_if.slave: pixel stream and ppfifo write port
//   o_frame_count  number of end-of-frame pixels accepted (wraps)
module pixel_writer
  import pixel_fifo_pkg::*;
#(
  parameter int unsigned SIZE_WIDTH    = 24,
  parameter bit          FLUSH_ON_LAST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_enable,
  pixel_writer_if.slave   bus,
  output logic [31:0]     o_frame_count
);

  writer_state_e             state_q, state_d;
  logic [SIZE_WIDTH-1:0]     count_q, count_d;
  logic [SIZE_WIDTH-1:0]     count_inc;
  logic [1:0]                act_q, act_d;
  logic                      stb_q, stb_d;
  logic [PIX_WORD_WIDTH-1:0] data_q, data_d;
  logic [31:0]               frame_q, frame_d;
  logic                      pixel_rdy;
  logic                      xfer;

  // Ready depends on registered state only, never on i_pixel_valid.
  assign pixel_rdy = (state_q == ACTIVE) && i_enable && (count_q < bus.i_write_size);
  assign xfer      = pixel_rdy && bus.i_pixel_valid;
  assign count_inc = count_q + SIZE_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    act_d   = act_q;
    stb_d   = 1'b0;
    data_d  = data_q;
    frame_d = frame_q;

    if (xfer && bus.i_last) begin
      frame_d = frame_q + 32'd1;
    end

    unique case (state_q)
      IDLE: begin
        if ((act_q == 2'b00) && (bus.i_write_rdy != 2'b00)) begin
          // Buffer 0 has priority when both are available.
          act_d   = bus.i_write_rdy[0] ? 2'b01 : 2'b10;
          count_d = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (bus.i_write_size == '0) begin
          // Zero-sized buffer could never fill; hand it straight back.
          act_d   = 2'b00;
          state_d = RELEASE;
        end else if (xfer) begin
          stb_d                          = 1'b1;
          data_d[PIX_LAST_BIT]           = bus.i_last;
          data_d[PIX_R_MSB:PIX_R_LSB]    = bus.i_red;
          data_d[PIX_G_MSB:PIX_G_LSB]    = bus.i_green;
          data_d[PIX_B_MSB:PIX_B_LSB]    = bus.i_blue;
          count_d                        = count_inc;
          if ((count_inc == bus.i_write_size) || (FLUSH_ON_LAST && bus.i_last)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Final strobe is on the bus this cycle with act still high.
        act_d   = 2'b00;
        state_d = RELEASE;
      end
      RELEASE: begin
        act_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        act_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      act_q   <= 2'b00;
      stb_q   <= 1'b0;
      data_q  <= '0;
      frame_q <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      act_q   <= act_d;
      stb_q   <= stb_d;
      data_q  <= data_d;
      frame_q <= frame_d;
    end
  end

  assign bus.o_pixel_rdy  = pixel_rdy;
  assign bus.o_write_act  = act_q;
  assign bus.o_write_stb  = stb_q;
  assign bus.o_write_data = data_q;
  assign o_frame_count    = frame_q;

endmodule
